// File: rtl/spi_master_pkg.sv
// Shared FSM encodings, SPI mode constants and width helpers for the SPI master.
package spi_master_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Width of the chip-select index
    function automatic int unsigned cs_width(input int unsigned num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

    // Width of the bits-remaining counter (must hold DATA_W itself)
    function automatic int unsigned cnt_width(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

    // Modes 0 and 2 sample on the leading SCLK edge, modes 1 and 3 on the trailing edge
    function automatic bit sample_on_lead(input logic [1:0] mode);
        case (mode)
            SPI_MODE0, SPI_MODE2: return 1'b1;
            SPI_MODE1, SPI_MODE3: return 1'b0;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Controller-side handshake bundle: start/busy/done plus the data words and CS index.
interface spi_master_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_CS = 1
);
    import spi_master_pkg::*;

    localparam int unsigned CS_W  = cs_width(NUM_CS);
    localparam int unsigned CNT_W = cnt_width(DATA_W);

    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [CS_W-1:0]   cs_sel;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic [CNT_W-1:0]  counter;

    // Local controller side
    modport master (
        output start, tx_data, cs_sel,
        input  busy, done, rx_data, counter
    );

    // SPI master side
    modport slave (
        input  start, tx_data, cs_sel,
        output busy, done, rx_data, counter
    );

endinterface

// File: rtl/spi_master_clk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV enabled cycles and flags the edge about to happen.
module spi_master_clk_gen #(
    parameter int unsigned CLK_DIV = 2,
    parameter bit          CPOL    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic sclk,
    output logic lead_edge,
    output logic trail_edge
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             tick;

    // Strobes mark the clk edge at which sclk_q changes level
    assign tick       = en && (div_q == DIV_W'(CLK_DIV - 1));
    assign lead_edge  = tick && (sclk_q == CPOL);
    assign trail_edge = tick && (sclk_q != CPOL);
    assign sclk       = sclk_q;

    // Divider phase and SCLK level
    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        if (clear) begin
            div_d  = '0;
            sclk_d = CPOL;
        end else if (en) begin
            if (tick) begin
                div_d  = '0;
                sclk_d = ~sclk_q;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            sclk_q <= CPOL;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Full-duplex SPI master: frame FSM, tx/rx shift registers, bit counter and CS decode.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CLK_DIV   = 2,
    parameter bit          CPOL      = 1'b0,
    parameter bit          CPHA      = 1'b0,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned NUM_CS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    spi_master_if.slave       ctrl,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_cs_L,
    output logic              spi_sclk,
    output logic              spi_data
);

    localparam int unsigned CS_W        = cs_width(NUM_CS);
    localparam int unsigned CNT_W       = cnt_width(DATA_W);
    localparam int unsigned TMR_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam bit          SAMPLE_LEAD = sample_on_lead({CPOL, CPHA});

    logic [2:0]        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CS_W-1:0]   cs_sel_q, cs_sel_d;
    logic [NUM_CS-1:0] cs_l_q, cs_l_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic accept, lead_edge, trail_edge, sample_edge, shift_edge;

    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    assign accept      = (state_q == ST_IDLE) && ctrl.start;
    assign sample_edge = SAMPLE_LEAD ? lead_edge : trail_edge;
    assign shift_edge  = SAMPLE_LEAD ? trail_edge : lead_edge;

    spi_master_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .CPOL    (CPOL)
    ) u_clk_gen (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept),
        .en         (state_q == ST_SHIFT),
        .sclk       (spi_sclk),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge)
    );

    // Frame sequencing and datapath next state
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        cnt_d     = cnt_q;
        cs_sel_d  = cs_sel_q;
        mosi_d    = mosi_q;
        case (state_q)
            ST_IDLE: begin
                if (ctrl.start) begin
                    state_d  = ST_SETUP;
                    tmr_d    = '0;
                    cs_sel_d = ctrl.cs_sel;
                    cnt_d    = CNT_W'(DATA_W);
                    // CPHA=0 puts the first bit out before any SCLK edge
                    if (CPHA) begin
                        tx_d = ctrl.tx_data;
                    end else begin
                        tx_d   = shift_word(ctrl.tx_data);
                        mosi_d = head_bit(ctrl.tx_data);
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_q == TMR_W'(CLK_DIV - 1)) begin
                    state_d = ST_SHIFT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (sample_edge) begin
                    rx_sh_d = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], spi_miso}
                                        : {spi_miso, rx_sh_q[DATA_W-1:1]};
                    cnt_d   = cnt_q - 1'b1;
                end
                // Once every bit is sampled the trailing shift edge must not move MOSI
                if (shift_edge && (cnt_q != '0)) begin
                    mosi_d = head_bit(tx_q);
                    tx_d   = shift_word(tx_q);
                end
                if (trail_edge && (cnt_d == '0)) begin
                    state_d = ST_HOLD;
                    tmr_d   = '0;
                end
            end
            ST_HOLD: begin
                if (tmr_q == TMR_W'(CLK_DIV - 1)) begin
                    state_d   = ST_DONE;
                    rx_data_d = rx_sh_q;
                    cnt_d     = CNT_W'(DATA_W);
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered status and chip-select outputs derived from the next state
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        cs_l_d = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (busy_d && (cs_sel_d == CS_W'(i))) cs_l_d[i] = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            cnt_q     <= CNT_W'(DATA_W);
            cs_sel_q  <= '0;
            cs_l_q    <= '1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            cnt_q     <= cnt_d;
            cs_sel_q  <= cs_sel_d;
            cs_l_q    <= cs_l_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ctrl.busy    = busy_q;
    assign ctrl.done    = done_q;
    assign ctrl.rx_data = rx_data_q;
    assign ctrl.counter = cnt_q;
    assign spi_cs_L     = cs_l_q;
    assign spi_data     = mosi_q;

endmodule
